// File: rtl/serial_tx_piso.sv
// serial_tx_piso: framed PISO transmitter (start, WIDTH data bits LSB-first, stop).
// Optional even parity bit between data and stop when PARITY_EN is defined.
module serial_tx_piso #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             tx_out,
   output logic             busy,
   output logic             done
);
   localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
   localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;
   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_n;
   logic [CW-1:0]    cyc;
   logic [BW-1:0]    bit_cnt;
   logic             bit_end;
`ifdef PARITY_EN
   logic             par;
`endif
   assign sh_n    = sh >> 1;
   assign bit_end = cyc == CYC_LAST;
   // frame sequencer: every bit state lasts BIT_CYCLES clocks; all outputs registered
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         tx_out     <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b1;
         sh         <= '0;
         cyc        <= '0;
         bit_cnt    <= '0;
`ifdef PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         cyc  <= (state == IDLE || bit_end) ? '0 : cyc + 1'b1;
         case (state)
            IDLE: if (load_valid) begin
               sh         <= data_in;
               bit_cnt    <= '0;
               state      <= START;
               tx_out     <= 1'b0;
               busy       <= 1'b1;
               load_ready <= 1'b0;
`ifdef PARITY_EN
               par        <= ^data_in;
`endif
            end
            START: if (bit_end) begin
               state  <= DATA;
               tx_out <= sh[0];
            end
            DATA: if (bit_end) begin
               if (bit_cnt == BIT_LAST) begin
`ifdef PARITY_EN
                  state  <= PARITY;
                  tx_out <= par;
`else
                  state  <= STOP;
                  tx_out <= 1'b1;
`endif
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  sh      <= sh_n;
                  tx_out  <= sh_n[0];
               end
            end
`ifdef PARITY_EN
            PARITY: if (bit_end) begin
               state  <= STOP;
               tx_out <= 1'b1;
            end
`endif
            STOP: if (bit_end) begin
               state      <= IDLE;
               busy       <= 1'b0;
               load_ready <= 1'b1;
               done       <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
